game_engine: RTL and testbench



---
 rtl/game_pkg.sv | 33 +++
 rtl/game_engine_key_edge.sv | 38 +++
 rtl/game_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_game_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared codes and helpers for the finger-addition game controller.
package game_pkg;

    typedef enum logic [1:0] {
        PAGE_MAIN   = 2'd0,
        PAGE_HELP   = 2'd1,
        PAGE_CONFIG = 2'd2,
        PAGE_GAME   = 2'd3
    } page_e;

    typedef enum logic [1:0] {
        END_RUN  = 2'd0,
        END_P0   = 2'd1,
        END_P1   = 2'd2,
        END_DRAW = 2'd3
    } end_e;

    localparam int NKEYS     = 5;
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_SPACE = 4;

    // Operands are already reduced, so the sum is below 2*m and one subtract suffices.
    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int unsigned s;
        s = a + b;
        return (s >= m) ? (s - m) : s;
    endfunction

endpackage

// File: rtl/game_engine_key_edge.sv
// Tick-gated rising-edge detector; the lowest-index key edge wins and is reported one-hot.
module key_edge
    import game_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [NKEYS-1:0] key_i,
    output logic [NKEYS-1:0] act_o,
    output logic             vld_o
);

    logic [NKEYS-1:0] prev_q;
    logic [NKEYS-1:0] prev_d;
    logic [NKEYS-1:0] rise;

    always_comb begin
        prev_d = prev_q;
        rise   = '0;
        if (tick_i) begin
            rise   = key_i & ~prev_q;
            prev_d = key_i;
        end
    end

    // Isolating the lowest set bit implements up > left > right > down > space.
    assign act_o = rise & (~rise + NKEYS'(1));
    assign vld_o = |rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/game_engine.sv
// Game-state controller: page navigation, cursor/selection, move legality,
// mod-MOD hand arithmetic and win/draw detection.
module game_engine
    import game_pkg::*;
#(
    parameter int MAX_SLOTS  = 5,
    parameter int MIN_SLOTS  = 2,
    parameter int DW         = 4,
    parameter int MOD        = 10,
    parameter int DRAW_LIMIT = 2,
    parameter int SW         = $clog2(MAX_SLOTS)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      tick,
    input  logic [4:0]                key_in,
    output logic [1:0]                page,
    output logic [SW:0]               total_number,
    output logic [2*MAX_SLOTS*DW-1:0] status,
    output logic                      cur_player,
    output logic                      cur_row,
    output logic                      sel_row,
    output logic [SW-1:0]             cur_col,
    output logic [SW-1:0]             sel_col,
    output logic                      selecting,
    output logic [DW-1:0]             predict,
    output logic [SW:0]               zero_cnt0,
    output logic [SW:0]               zero_cnt1,
    output logic [1:0]                game_end
);

    localparam logic [SW:0]   ONE_CNT = (SW + 1)'(1);
    localparam logic [SW:0]   MIN_CNT = (SW + 1)'(MIN_SLOTS);
    localparam logic [SW:0]   MAX_CNT = (SW + 1)'(MAX_SLOTS);
    localparam logic [SW-1:0] ONE_COL = SW'(1);
    localparam logic [DW-1:0] ONE_V   = DW'(1);

    page_e                 page_q, page_d;
    end_e                  end_q, end_d;
    logic [SW:0]           total_q, total_d;
    logic [DW-1:0]         st_q [2][MAX_SLOTS];
    logic [DW-1:0]         st_d [2][MAX_SLOTS];
    logic                  player_q, player_d;
    logic                  crow_q, crow_d, srow_q, srow_d;
    logic [SW-1:0]         ccol_q, ccol_d, scol_q, scol_d;
    logic                  selecting_q, selecting_d;
    logic [SW:0]           zc_q [2];
    logic [SW:0]           zc_d [2];
    logic [DRAW_LIMIT-1:0] hist_q, hist_d;
    logic [DW-1:0]         pred_q;

    logic [NKEYS-1:0]      act;
    logic                  act_vld;
    logic [DW-1:0]         cur_v, sel_v, own_v, other_v, sum_v;
    logic [SW-1:0]         own_col, last_col;
    logic [SW:0]           last_cnt;
    logic                  own_is_cur;

    key_edge u_key_edge (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .tick_i (tick),
        .key_i  (key_in),
        .act_o  (act),
        .vld_o  (act_vld)
    );

    // The operand lying in the mover's row is the one that gets updated.
    assign cur_v      = st_q[crow_q][ccol_q];
    assign sel_v      = st_q[srow_q][scol_q];
    assign own_is_cur = (crow_q == player_q);
    assign own_col    = own_is_cur ? ccol_q : scol_q;
    assign own_v      = own_is_cur ? cur_v : sel_v;
    assign other_v    = own_is_cur ? sel_v : cur_v;
    assign sum_v      = DW'(mod_add(32'(own_v), 32'(other_v), 32'(MOD)));
    assign last_cnt   = total_q - ONE_CNT;
    assign last_col   = last_cnt[SW-1:0];

    always_comb begin
        page_d      = page_q;
        total_d     = total_q;
        st_d        = st_q;
        player_d    = player_q;
        crow_d      = crow_q;
        ccol_d      = ccol_q;
        srow_d      = srow_q;
        scol_d      = scol_q;
        selecting_d = selecting_q;
        zc_d        = zc_q;
        hist_d      = hist_q;
        end_d       = end_q;
        if (act_vld) begin
            case (page_q)
                PAGE_MAIN: begin
                    if (act[KEY_UP])        page_d = PAGE_CONFIG;
                    else if (act[KEY_DOWN]) page_d = PAGE_HELP;
                end
                PAGE_HELP: begin
                    if (act[KEY_DOWN]) page_d = PAGE_MAIN;
                end
                PAGE_CONFIG: begin
                    if (act[KEY_LEFT]) begin
                        if (total_q > MIN_CNT) total_d = total_q - ONE_CNT;
                    end else if (act[KEY_RIGHT]) begin
                        if (total_q < MAX_CNT) total_d = total_q + ONE_CNT;
                    end else if (act[KEY_DOWN]) begin
                        page_d = PAGE_MAIN;
                    end else if (act[KEY_UP]) begin
                        page_d = PAGE_GAME;
                        for (int r = 0; r < 2; r++) begin
                            for (int s = 0; s < MAX_SLOTS; s++) begin
                                st_d[r][s] = (s < int'(total_q)) ? ONE_V : '0;
                            end
                        end
                        player_d    = 1'b0;
                        selecting_d = 1'b0;
                        crow_d      = 1'b0;
                        ccol_d      = '0;
                        zc_d[0]     = '0;
                        zc_d[1]     = '0;
                        hist_d      = '0;
                        end_d       = END_RUN;
                    end
                end
                PAGE_GAME: begin
                    if (end_q != END_RUN) begin
                        if (act[KEY_DOWN]) page_d = PAGE_MAIN;
                    end else if (act[KEY_UP] || act[KEY_DOWN]) begin
                        crow_d = ~crow_q;
                    end else if (act[KEY_LEFT]) begin
                        ccol_d = (ccol_q == '0) ? last_col : ccol_q - ONE_COL;
                    end else if (act[KEY_RIGHT]) begin
                        ccol_d = ({1'b0, ccol_q} == last_cnt) ? '0 : ccol_q + ONE_COL;
                    end else if (act[KEY_SPACE]) begin
                        if (!selecting_q) begin
                            srow_d      = crow_q;
                            scol_d      = ccol_q;
                            selecting_d = 1'b1;
                        end else begin
                            selecting_d = 1'b0;
                            // Same-row pairs cancel; a zero own hand cannot move.
                            if (crow_q != srow_q && own_v != '0) begin
                                st_d[player_q][own_col] = sum_v;
                                hist_d = DRAW_LIMIT'({hist_q, other_v == '0});
                                if (sum_v == '0) zc_d[player_q] = zc_q[player_q] + ONE_CNT;
                                player_d = ~player_q;
                                if (zc_d[0] == total_q)      end_d = END_P0;
                                else if (zc_d[1] == total_q) end_d = END_P1;
                                else if (&hist_d)            end_d = END_DRAW;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            page_q      <= PAGE_MAIN;
            total_q     <= MIN_CNT;
            for (int r = 0; r < 2; r++) begin
                for (int s = 0; s < MAX_SLOTS; s++) begin
                    st_q[r][s] <= ONE_V;
                end
            end
            player_q    <= 1'b0;
            crow_q      <= 1'b0;
            ccol_q      <= '0;
            srow_q      <= 1'b0;
            scol_q      <= '0;
            selecting_q <= 1'b0;
            zc_q[0]     <= '0;
            zc_q[1]     <= '0;
            hist_q      <= '0;
            end_q       <= END_RUN;
        end else begin
            page_q      <= page_d;
            total_q     <= total_d;
            st_q        <= st_d;
            player_q    <= player_d;
            crow_q      <= crow_d;
            ccol_q      <= ccol_d;
            srow_q      <= srow_d;
            scol_q      <= scol_d;
            selecting_q <= selecting_d;
            zc_q        <= zc_d;
            hist_q      <= hist_d;
            end_q       <= end_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        pred_q <= DW'(mod_add(32'(cur_v), 32'(sel_v), 32'(MOD)));
    end

    always_comb begin
        status = '0;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < MAX_SLOTS; s++) begin
                status[(r*MAX_SLOTS+s)*DW +: DW] = st_q[r][s];
            end
        end
    end

    assign page         = page_q;
    assign total_number = total_q;
    assign cur_player   = player_q;
    assign cur_row      = crow_q;
    assign sel_row      = srow_q;
    assign cur_col      = ccol_q;
    assign sel_col      = scol_q;
    assign selecting    = selecting_q;
    assign predict      = pred_q;
    assign zero_cnt0    = zc_q[0];
    assign zero_cnt1    = zc_q[1];
    assign game_end     = end_q;

endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: directed game scripts plus random key traffic against a behavioural model.
module tb_game_engine;

    localparam int MAX_SLOTS  = 5;
    localparam int MIN_SLOTS  = 2;
    localparam int DW         = 4;
    localparam int MOD        = 10;
    localparam int DRAW_LIMIT = 2;
    localparam int SW         = $clog2(MAX_SLOTS);

    localparam logic [4:0] K_UP    = 5'b00001;
    localparam logic [4:0] K_LEFT  = 5'b00010;
    localparam logic [4:0] K_RIGHT = 5'b00100;
    localparam logic [4:0] K_DOWN  = 5'b01000;
    localparam logic [4:0] K_SPACE = 5'b10000;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst = 1'b1;
    logic                      tick    = 1'b0;
    logic [4:0]                key_in  = '0;
    logic [1:0]                page;
    logic [SW:0]               total_number;
    logic [2*MAX_SLOTS*DW-1:0] status;
    logic                      cur_player, cur_row, sel_row, selecting;
    logic [SW-1:0]             cur_col, sel_col;
    logic [DW-1:0]             predict;
    logic [SW:0]               zero_cnt0, zero_cnt1;
    logic [1:0]                game_end;

    game_engine #(
        .MAX_SLOTS(MAX_SLOTS), .MIN_SLOTS(MIN_SLOTS), .DW(DW),
        .MOD(MOD), .DRAW_LIMIT(DRAW_LIMIT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .key_in(key_in),
        .page(page), .total_number(total_number), .status(status),
        .cur_player(cur_player), .cur_row(cur_row), .sel_row(sel_row),
        .cur_col(cur_col), .sel_col(sel_col), .selecting(selecting),
        .predict(predict), .zero_cnt0(zero_cnt0), .zero_cnt1(zero_cnt1),
        .game_end(game_end)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: plain integers, game rules applied directly.
    int         m_page, m_total, m_player, m_crow, m_ccol, m_srow, m_scol, m_sel;
    int         m_zc [2];
    int         m_st [2][MAX_SLOTS];
    int         m_run, m_end, m_pred;
    logic [4:0] m_prev;
    bit         m_pred_ok;
    bit         chk_en = 1'b0;
    int         n_cmp  = 0;
    int         n_bad  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_page = 0; m_total = MIN_SLOTS; m_player = 0;
        m_crow = 0; m_ccol = 0; m_srow = 0; m_scol = 0; m_sel = 0;
        m_zc[0] = 0; m_zc[1] = 0; m_run = 0; m_end = 0; m_prev = '0;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < MAX_SLOTS; s++) m_st[r][s] = 1;
    endtask

    task automatic model_space();
        int orow, ocol, xrow, xcol;
        if (m_sel == 0) begin
            m_srow = m_crow; m_scol = m_ccol; m_sel = 1;
            return;
        end
        m_sel = 0;
        if (m_crow == m_srow) return;
        if (m_crow == m_player) begin
            orow = m_crow; ocol = m_ccol; xrow = m_srow; xcol = m_scol;
        end else begin
            orow = m_srow; ocol = m_scol; xrow = m_crow; xcol = m_ccol;
        end
        if (m_st[orow][ocol] == 0) return;
        m_st[orow][ocol] = (m_st[orow][ocol] + m_st[xrow][xcol]) % MOD;
        m_run = (m_st[xrow][xcol] == 0) ? m_run + 1 : 0;
        if (m_st[orow][ocol] == 0) m_zc[m_player]++;
        m_player = 1 - m_player;
        if (m_zc[0] == m_total)      m_end = 1;
        else if (m_zc[1] == m_total) m_end = 2;
        else if (m_run >= DRAW_LIMIT) m_end = 3;
    endtask

    task automatic model_key(input int k);
        case (m_page)
            0: if (k == 0) m_page = 2; else if (k == 3) m_page = 1;
            1: if (k == 3) m_page = 0;
            2: begin
                if (k == 1 && m_total > MIN_SLOTS) m_total--;
                else if (k == 2 && m_total < MAX_SLOTS) m_total++;
                else if (k == 3) m_page = 0;
                else if (k == 0) begin
                    m_page = 3;
                    for (int r = 0; r < 2; r++)
                        for (int s = 0; s < MAX_SLOTS; s++) m_st[r][s] = (s < m_total) ? 1 : 0;
                    m_player = 0; m_sel = 0; m_crow = 0; m_ccol = 0;
                    m_zc[0] = 0; m_zc[1] = 0; m_run = 0; m_end = 0;
                end
            end
            default: begin
                if (m_end != 0) begin
                    if (k == 3) m_page = 0;
                end else if (k == 0 || k == 3) m_crow = 1 - m_crow;
                else if (k == 1) m_ccol = (m_ccol + m_total - 1) % m_total;
                else if (k == 2) m_ccol = (m_ccol + 1) % m_total;
                else model_space();
            end
        endcase
    endtask

    task automatic model_edge();
        logic [4:0] rise;
        int pre_sel;
        m_pred  = (m_st[m_crow][m_ccol] + m_st[m_srow][m_scol]) % MOD;
        pre_sel = m_sel;
        if (sys_rst) begin
            model_reset();
        end else if (tick) begin
            rise   = key_in & ~m_prev;
            m_prev = key_in;
            for (int k = 0; k < 5; k++) begin
                if (rise[k]) begin
                    model_key(k);
                    break;
                end
            end
        end
        m_pred_ok = (pre_sel == 1) && (m_sel == 1);
    endtask

    function automatic logic [63:0] exp_status();
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < MAX_SLOTS; s++) v[(r*MAX_SLOTS+s)*DW +: DW] = DW'(m_st[r][s]);
        return v;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_en) begin
                chk("page", page, m_page);
                chk("total_number", total_number, m_total);
                chk("status", status, exp_status());
                chk("cur_player", cur_player, m_player);
                chk("cur_row", cur_row, m_crow);
                chk("cur_col", cur_col, m_ccol);
                chk("sel_row", sel_row, m_srow);
                chk("sel_col", sel_col, m_scol);
                chk("selecting", selecting, m_sel);
                chk("zero_cnt0", zero_cnt0, m_zc[0]);
                chk("zero_cnt1", zero_cnt1, m_zc[1]);
                chk("game_end", game_end, m_end);
                if (m_pred_ok) chk("predict", predict, m_pred);
            end
        end
    end

    task automatic step(input bit t, input logic [4:0] k);
        tick   = t;
        key_in = k;
        @(posedge sys_clk);
        model_edge();
        #1;
        tick = 1'b0;
    endtask

    task automatic press(input logic [4:0] k);
        step(1'b1, k);
        step(1'b1, 5'b0);
    endtask

    task automatic goto_cell(input int r, input int c);
        for (int i = 0; i < 4 && m_crow != r; i++) press(K_UP);
        for (int i = 0; i < MAX_SLOTS + 1 && m_ccol != c; i++) press(K_RIGHT);
    endtask

    task automatic move(input int own_c, input int oth_c, input int exp_pred);
        int p;
        p = m_player;
        goto_cell(p, own_c);
        press(K_SPACE);
        goto_cell(1 - p, oth_c);
        step(1'b0, 5'b0);
        if (exp_pred >= 0) chk("lit_predict", predict, exp_pred);
        press(K_SPACE);
    endtask

    task automatic enter_game();
        press(K_UP);
        press(K_UP);
    endtask

    task automatic first_nine();
        move(0, 0, 2);
        chk("lit_move1_a0", status[3:0], 2);
        chk("lit_move1_player", cur_player, 1);
        move(0, 0, -1); move(0, 0, -1); move(0, 0, -1);
        move(1, 0, -1); move(1, 1, -1);
        chk("lit_p1_zero", zero_cnt1, 1);
        move(0, 0, -1); move(0, 0, -1); move(1, 0, -1);
        chk("lit_p0_zero", zero_cnt0, 1);
    endtask

    initial begin
        model_reset();
        m_pred_ok = 1'b0;
        step(1'b0, 5'b0);
        step(1'b0, 5'b0);
        sys_rst = 1'b0;
        chk_en  = 1'b1;
        chk("lit_rst_page", page, 0);
        chk("lit_rst_total", total_number, MIN_SLOTS);
        chk("lit_rst_end", game_end, 0);

        press(K_UP);
        chk("lit_config", page, 2);
        for (int i = 0; i < 5; i++) press(K_RIGHT);
        chk("lit_total_max", total_number, 5);
        for (int i = 0; i < 5; i++) press(K_LEFT);
        chk("lit_total_min", total_number, 2);
        press(K_UP);
        chk("lit_game", page, 3);
        chk("lit_game_status", status, 40'h0001100011);

        press(K_UP | K_SPACE);
        chk("lit_prio_row", cur_row, 1);
        chk("lit_prio_sel", selecting, 0);
        press(K_UP);

        goto_cell(0, 0);
        press(K_SPACE);
        goto_cell(0, 1);
        press(K_SPACE);
        chk("lit_cancel_sel", selecting, 0);
        chk("lit_cancel_player", cur_player, 0);
        chk("lit_cancel_status", status, 40'h0001100011);

        // Game A: both players reach one zero hand, then two zero-adds in a row.
        first_nine();
        move(0, 1, -1);
        move(0, 1, -1);
        chk("lit_draw", game_end, 3);
        chk("lit_draw_a0", status[3:0], 3);
        press(K_DOWN);
        chk("lit_draw_main", page, 0);

        // Game B: illegal zero-hand move, then P0 sweeps its hands to zero.
        enter_game();
        first_nine();
        move(1, 0, -1);
        chk("lit_illegal_player", cur_player, 1);
        chk("lit_illegal_status", status, 40'h0000100003);
        for (int i = 0; i < 7; i++) begin
            move(0, 1, -1);
            move(0, 0, -1);
        end
        chk("lit_p0_win", game_end, 1);
        chk("lit_p0_win_cnt", zero_cnt0, 2);
        press(K_DOWN);
        chk("lit_win_main", page, 0);

        for (int i = 0; i < 20000; i++) begin
            int         r;
            logic [4:0] k;
            r = $urandom_range(0, 99);
            if (r < 45)      k = 5'b1 << $urandom_range(0, 4);
            else if (r < 60) k = 5'($urandom);
            else             k = 5'b0;
            sys_rst = ($urandom_range(0, 2999) == 0);
            step($urandom_range(0, 3) != 0, k);
        end
        sys_rst = 1'b0;
        step(1'b0, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
